// File: rtl/execute_pkg.sv
// Shared execute-stage types: ALU opcodes, FSM states and the six-bit control word.
// Also used by decode and by the execute/memory register.
package execute_pkg;

  localparam int EXEC_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } exec_state_e;

  typedef struct packed {
    logic wbs;
    logic wme;
    logic mm;
    logic wm;
    logic am;
    logic ni;
  } ctrl_t;

  function automatic logic is_mul(input alu_op_e op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low W bits of the product.
// Latency W cycles after start; abort returns it to idle immediately with no result.
// done pulses on the final iteration with product already including that last partial sum.
module seq_multiplier
  import execute_pkg::*;
#(
  parameter int W = EXEC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  acc_next;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == LAST);

    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign product = acc_next;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU plus output register; optional {N,Z,C,V} flags under EXEC_FLAGS_EN.
// Latency 1 for single-cycle ops, W+1 for MUL; stall_out holds upstream for the W MUL cycles.
// flush squashes the current/next instruction and aborts a MUL in flight.
module execute_stage
  import execute_pkg::*;
#(
  parameter int W = EXEC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         wbs_in,
  input  logic         wme_in,
  input  logic         mm_in,
  input  logic         wm_in,
  input  logic         am_in,
  input  logic         ni_in,
  input  logic [2:0]   ALUop_in,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] store_data_in,
  input  logic         flush,
  output logic         stall_out,
  output logic         out_valid,
  output logic [W-1:0] alu_result,
  output logic [W-1:0] store_data_out,
  output logic         wbs_out,
  output logic         wme_out,
  output logic         mm_out,
  output logic         wm_out,
  output logic         am_out,
  output logic         ni_out
`ifdef EXEC_FLAGS_EN
  ,
  output logic [3:0]   flags
`endif
);

  localparam int SHW = $clog2(W);

  exec_state_e state_q, state_d;
  logic        out_valid_q, out_valid_d;
  ctrl_t       ctrl_q, ctrl_d;
  ctrl_t       ctrl_hold_q, ctrl_hold_d;
  logic [W-1:0] alu_result_q, alu_result_d;
  logic [W-1:0] store_data_q, store_data_d;
  logic [W-1:0] store_hold_q, store_hold_d;

  ctrl_t        ctrl_in;
  alu_op_e      op;
  logic [W-1:0] alu_res;
  logic         mul_start, mul_abort, mul_busy, mul_done;
  logic [W-1:0] mul_product;

  assign ctrl_in = {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
  assign op      = alu_op_e'(ALUop_in);

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << op_b[SHW-1:0];
      ALU_SRL: alu_res = op_a >> op_b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags;
  logic       a_msb, b_msb, r_msb;

  // Carry and overflow come from operand/result sign bits, so no widened adder is needed.
  always_comb begin
    a_msb     = op_a[W-1];
    b_msb     = op_b[W-1];
    r_msb     = alu_res[W-1];
    alu_flags = {r_msb, alu_res == '0, 2'b00};
    case (op)
      ALU_ADD: begin
        alu_flags[1] = (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
        alu_flags[0] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      ALU_SUB: begin
        alu_flags[1] = op_a >= op_b;
        alu_flags[0] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      default: ;
    endcase
  end
`endif

  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    ctrl_d       = '0;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    ctrl_hold_d  = ctrl_hold_q;
    store_hold_d = store_hold_q;
    mul_start    = 1'b0;
    mul_abort    = 1'b0;
`ifdef EXEC_FLAGS_EN
    flags_d      = flags_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (is_mul(op)) begin
            mul_start    = 1'b1;
            ctrl_hold_d  = ctrl_in;
            store_hold_d = store_data_in;
            state_d      = BUSY;
          end else begin
            out_valid_d  = 1'b1;
            ctrl_d       = ctrl_in;
            alu_result_d = alu_res;
            store_data_d = store_data_in;
`ifdef EXEC_FLAGS_EN
            flags_d      = alu_flags;
`endif
          end
        end
      end
      BUSY: begin
        if (flush) begin
          mul_abort = 1'b1;
          state_d   = IDLE;
        end else if (mul_done && mul_busy) begin
          state_d      = IDLE;
          out_valid_d  = 1'b1;
          ctrl_d       = ctrl_hold_q;
          alu_result_d = mul_product;
          store_data_d = store_hold_q;
`ifdef EXEC_FLAGS_EN
          flags_d      = {mul_product[W-1], mul_product == '0, 2'b00};
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      ctrl_q       <= '0;
      ctrl_hold_q  <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      store_hold_q <= '0;
`ifdef EXEC_FLAGS_EN
      flags_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      ctrl_q       <= ctrl_d;
      ctrl_hold_q  <= ctrl_hold_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      store_hold_q <= store_hold_d;
`ifdef EXEC_FLAGS_EN
      flags_q      <= flags_d;
`endif
    end
  end

  seq_multiplier #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign stall_out      = (state_q == BUSY);
  assign out_valid      = out_valid_q;
  assign alu_result     = alu_result_q;
  assign store_data_out = store_data_q;
  assign wbs_out        = ctrl_q.wbs;
  assign wme_out        = ctrl_q.wme;
  assign mm_out         = ctrl_q.mm;
  assign wm_out         = ctrl_q.wm;
  assign am_out         = ctrl_q.am;
  assign ni_out         = ctrl_q.ni;
`ifdef EXEC_FLAGS_EN
  assign flags          = flags_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: transaction-level reference model compared every
// negedge, plus directed vectors with literal expectations. Flag checks need EXEC_FLAGS_EN.
module tb_execute_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         wbs_in = 1'b0, wme_in = 1'b0, mm_in = 1'b0, wm_in = 1'b0, am_in = 1'b0, ni_in = 1'b0;
  logic [2:0]   ALUop_in = 3'd0;
  logic [W-1:0] op_a = '0, op_b = '0, store_data_in = '0;
  logic         flush = 1'b0;
  logic         stall_out, out_valid;
  logic [W-1:0] alu_result, store_data_out;
  logic         wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
`ifdef EXEC_FLAGS_EN
  logic [3:0]   flags;
`endif

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in), .am_in(am_in), .ni_in(ni_in),
    .ALUop_in(ALUop_in), .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in), .flush(flush),
    .stall_out(stall_out), .out_valid(out_valid), .alu_result(alu_result),
    .store_data_out(store_data_out),
    .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out), .wm_out(wm_out), .am_out(am_out),
    .ni_out(ni_out)
`ifdef EXEC_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % W);
      3'd6: return a >> (b % W);
      default: return a * b;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] r);
    longint sa, sb, s;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    if (op == 3'd0) begin
      c = (longint'(a) + longint'(b)) > 64'sd4294967295;
      s = sa + sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (op == 3'd1) begin
      c = a >= b;
      s = sa - sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    return {r[W-1], r == '0, c, v};
  endfunction

  int           m_left;
  logic [W-1:0] m_pa, m_pb, m_pstore, m_res, m_store;
  logic [5:0]   m_pctrl, m_ctrl;
  logic         m_valid;
  logic [3:0]   m_flags;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_pa = '0; m_pb = '0; m_pstore = '0; m_res = '0; m_store = '0;
      m_pctrl = '0; m_ctrl = '0; m_valid = 1'b0; m_flags = '0;
    end else begin
      m_valid = 1'b0;
      m_ctrl  = '0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_valid = 1'b1;
            m_res   = m_pa * m_pb;
            m_store = m_pstore;
            m_ctrl  = m_pctrl;
            m_flags = ref_flags(3'd7, m_pa, m_pb, m_res);
          end
        end
      end else if (in_valid && !flush) begin
        if (ALUop_in == 3'd7) begin
          m_left = W; m_pa = op_a; m_pb = op_b; m_pstore = store_data_in;
          m_pctrl = {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
        end else begin
          m_valid = 1'b1;
          m_res   = ref_alu(ALUop_in, op_a, op_b);
          m_store = store_data_in;
          m_ctrl  = {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
          m_flags = ref_flags(ALUop_in, op_a, op_b, m_res);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_out_valid", out_valid, m_valid);
    check("cmp_stall", stall_out, m_left > 0);
    check("cmp_ctrl", {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out}, m_ctrl);
    check("cmp_result", alu_result, m_res);
    check("cmp_store", store_data_out, m_store);
`ifdef EXEC_FLAGS_EN
    check("cmp_flags", flags, m_flags);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [5:0] c, input logic [W-1:0] sd,
                        input logic fl);
    in_valid = v; ALUop_in = op; op_a = a; op_b = b; store_data_in = sd; flush = fl;
    {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in} = c;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_out, 0);
    check("rst_result", alu_result, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: ADD 5+3 with wbs
    set_in(1, 3'd0, 5, 3, 6'b100000, 32'h1111, 0);
    step();
    check("add_valid", out_valid, 1);
    check("add_result", alu_result, 8);
    check("add_wbs", wbs_out, 1);
    check("add_store", store_data_out, 32'h1111);

    // 6: invalid slot with wme requested, then masked shift amount
    set_in(0, 3'd0, 9, 9, 6'b010000, 0, 0);
    step();
    check("bubble_wme", wme_out, 0);
    check("bubble_valid", out_valid, 0);
    check("bubble_hold", alu_result, 8);
    set_in(1, 3'd5, 1, 33, 6'b000000, 0, 0);
    step();
    check("sll_masked", alu_result, 2);

    // 2: SUB 3-5
    set_in(1, 3'd1, 3, 5, 6'b100000, 0, 0);
    step();
    check("sub_result", alu_result, 32'hFFFFFFFE);
`ifdef EXEC_FLAGS_EN
    check("sub_flags", flags, 4'b1000);
`endif

    set_in(1, 3'd2, 32'hF0F0, 32'h0FF0, 0, 0, 0); step(); check("and_result", alu_result, 32'h00F0);
    set_in(1, 3'd3, 32'hF0F0, 32'h0FF0, 0, 0, 0); step(); check("or_result", alu_result, 32'hFFF0);
    set_in(1, 3'd4, 32'hF0F0, 32'h0FF0, 0, 0, 0); step(); check("xor_result", alu_result, 32'hFF00);
    set_in(1, 3'd6, 32'h80000000, 31, 0, 0, 0);   step(); check("srl_result", alu_result, 1);
    set_in(1, 3'd0, 32'hFFFFFFFF, 1, 0, 0, 0);    step(); check("add_wrap", alu_result, 0);
`ifdef EXEC_FLAGS_EN
    check("add_wrap_flags", flags, 4'b0110);
`endif
    set_in(1, 3'd0, 32'h7FFFFFFF, 1, 0, 0, 0);    step(); check("add_ovf", alu_result, 32'h80000000);
`ifdef EXEC_FLAGS_EN
    check("add_ovf_flags", flags, 4'b1001);
`endif

    // flush together with in_valid: flush wins
    set_in(1, 3'd0, 4, 4, 6'b111111, 0, 1);
    step();
    check("flush_idle_valid", out_valid, 0);
    check("flush_idle_ctrl", {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out}, 0);

    // 3: MUL 7*6; inputs during BUSY are ignored
    set_in(1, 3'd7, 7, 6, 6'b000010, 32'hABCD, 0);
    step();
    check("mul_bubble_first", out_valid, 0);
    set_in(1, 3'd0, 9, 9, 6'b111111, 0, 0);
    n = 0;
    while (stall_out && n < 100) begin
      check("mul_bubble", out_valid, 0);
      if (n == W - 1) in_valid = 1'b0;
      step();
      n++;
    end
    check("mul_stall_cycles", n, 32);
    check("mul_valid", out_valid, 1);
    check("mul_result", alu_result, 42);
    check("mul_am", am_out, 1);
    check("mul_store", store_data_out, 32'hABCD);
    step();
    check("mul_one_cycle", out_valid, 0);
    check("mul_hold", alu_result, 42);

    // wrap-around product
    set_in(1, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    step();
    in_valid = 1'b0;
    repeat (W) step();
    check("mul_wrap", alu_result, 1);

    // 4: flush at BUSY cycle 10
    set_in(1, 3'd7, 123, 456, 6'b100000, 0, 0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    check("flush_busy_stall_before", stall_out, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_stall", stall_out, 0);
    check("flush_busy_valid", out_valid, 0);
    set_in(1, 3'd0, 1, 1, 0, 0, 0);
    step();
    check("after_flush_add", alu_result, 2);
    check("after_flush_valid", out_valid, 1);

    // 5: async reset mid-MUL
    set_in(1, 3'd7, 5, 5, 6'b111111, 32'h55, 0);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #1 rst = 1'b1;
    #1;
    check("arst_stall", stall_out, 0);
    check("arst_valid", out_valid, 0);
    check("arst_result", alu_result, 0);
    check("arst_store", store_data_out, 0);
    check("arst_ctrl", {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out}, 0);
    #2 rst = 1'b0;
    set_in(1, 3'd0, 20, 22, 6'b000001, 0, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_add", alu_result, 42);
    check("post_rst_ni", ni_out, 1);
    set_in(0, 3'd0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
